// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_if
// Description : ID-stage consumer/producer information going into the
//               hazard scoreboard, and the per-stage producer records, stall
//               and stall counter coming out of it.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
  parameter int TW    = 3,
  parameter int CNT_W = 32
);
  // Consumer and producer information for the instruction in ID
  logic [4:0]       RAddr0_ID;
  logic [4:0]       RAddr1_ID;
  logic [TW-1:0]    Tuse_RAddr0_ID;
  logic [TW-1:0]    Tuse_RAddr1_ID;
  logic [4:0]       RegWriteAddr_ID;
  logic [TW-1:0]    Tnew_ID;
  logic             flush;

  // Hazard result and per-stage producer records
  logic             stall;
  logic [4:0]       RegWriteAddr_EX;
  logic [TW-1:0]    Tnew_WAddr_EX;
  logic [4:0]       RegWriteAddr_Mem;
  logic [TW-1:0]    Tnew_WAddr_Mem;
  logic [4:0]       RegWriteAddr_WB;
  logic [CNT_W-1:0] stall_count;

  // Pipeline side: drives the ID information, consumes the results
  modport master (
    output RAddr0_ID, RAddr1_ID, Tuse_RAddr0_ID, Tuse_RAddr1_ID,
           RegWriteAddr_ID, Tnew_ID, flush,
    input  stall, RegWriteAddr_EX, Tnew_WAddr_EX, RegWriteAddr_Mem,
           Tnew_WAddr_Mem, RegWriteAddr_WB, stall_count
  );

  // Scoreboard side
  modport slave (
    input  RAddr0_ID, RAddr1_ID, Tuse_RAddr0_ID, Tuse_RAddr1_ID,
           RegWriteAddr_ID, Tnew_ID, flush,
    output stall, RegWriteAddr_EX, Tnew_WAddr_EX, RegWriteAddr_Mem,
           Tnew_WAddr_Mem, RegWriteAddr_WB, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Tracks destination register and remaining Tnew of the
//               instructions in EX, Mem and WB. Raises stall when an ID
//               consumer needs a value that forwarding cannot yet deliver,
//               bubbles EX while stalled, and counts stall cycles
//               (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int TW    = 3,
  parameter int CNT_W = 32
) (
  input  wire                  clk,
  input  wire                  reset,
  hazard_scoreboard_if.slave   bus
);

  localparam logic [TW-1:0]    c_tnew_one = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

  // Producer records; WB carries no Tnew because its value is always ready
  logic [4:0]       r_waddr_ex;
  logic [TW-1:0]    r_tnew_ex;
  logic [4:0]       r_waddr_mem;
  logic [TW-1:0]    r_tnew_mem;
  logic [4:0]       r_waddr_wb;
  logic [CNT_W-1:0] r_stall_count;

  // Per-source view of the consumer in ID
  logic [4:0]       w_raddr [2];
  logic [TW-1:0]    w_tuse  [2];
  logic [1:0]       w_hazard;
  logic             w_stall;
  logic             w_bubble;

  assign w_raddr[0] = bus.RAddr0_ID;
  assign w_raddr[1] = bus.RAddr1_ID;
  assign w_tuse[0]  = bus.Tuse_RAddr0_ID;
  assign w_tuse[1]  = bus.Tuse_RAddr1_ID;

  // The nearest in-flight producer of a register holds its newest value, so
  // an EX match hides any older Mem record of the same register. $0 is
  // hard-wired and never waits on anybody.
  genvar s;
  generate
    for (s = 0; s < 2; s++) begin : g_src
      logic w_nonzero;
      logic w_match_ex;
      logic w_match_mem;

      assign w_nonzero   = (w_raddr[s] != 5'd0);
      assign w_match_ex  = w_nonzero && (w_raddr[s] == r_waddr_ex);
      assign w_match_mem = w_nonzero && (w_raddr[s] == r_waddr_mem);

      assign w_hazard[s] = w_match_ex  ? (r_tnew_ex > w_tuse[s]) :
                           w_match_mem ? (r_tnew_mem > w_tuse[s]) :
                                         1'b0;
    end
  endgenerate

  // Stall only looks at registered records and the ID consumer fields
  assign w_stall  = |w_hazard;
  assign w_bubble = w_stall || bus.flush;

  // EX record: take the ID producer, or a bubble when stalled or flushed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_waddr_ex <= 5'd0;
      r_tnew_ex  <= '0;
    end else if (w_bubble) begin
      r_waddr_ex <= 5'd0;
      r_tnew_ex  <= '0;
    end else begin
      r_waddr_ex <= bus.RegWriteAddr_ID;
      r_tnew_ex  <= bus.Tnew_ID;
    end
  end

  // Mem and WB always advance; Tnew counts down by one and stops at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_waddr_mem <= 5'd0;
      r_tnew_mem  <= '0;
      r_waddr_wb  <= 5'd0;
    end else begin
      r_waddr_mem <= r_waddr_ex;
      r_tnew_mem  <= (r_tnew_ex == '0) ? '0 : (r_tnew_ex - c_tnew_one);
      r_waddr_wb  <= r_waddr_mem;
    end
  end

  // Stall-cycle counter, sticks at its maximum value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != c_cnt_max)) begin
      r_stall_count <= r_stall_count + c_cnt_one;
    end
  end

  assign bus.stall            = w_stall;
  assign bus.RegWriteAddr_EX  = r_waddr_ex;
  assign bus.Tnew_WAddr_EX    = r_tnew_ex;
  assign bus.RegWriteAddr_Mem = r_waddr_mem;
  assign bus.Tnew_WAddr_Mem   = r_tnew_mem;
  assign bus.RegWriteAddr_WB  = r_waddr_wb;
  assign bus.stall_count      = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Self-checking bench for hazard_scoreboard: directed vector
//               table, asynchronous reset during a stall, counter saturation
//               on a narrow-counter instance, and randomized traffic against
//               an instruction-history reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  localparam int TW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.TW(TW), .CNT_W(32)) bus ();
  hazard_scoreboard_if #(.TW(TW), .CNT_W(2))  bus_sat ();

  // The narrow-counter instance sees exactly the same ID traffic
  assign bus_sat.RAddr0_ID       = bus.RAddr0_ID;
  assign bus_sat.RAddr1_ID       = bus.RAddr1_ID;
  assign bus_sat.Tuse_RAddr0_ID  = bus.Tuse_RAddr0_ID;
  assign bus_sat.Tuse_RAddr1_ID  = bus.Tuse_RAddr1_ID;
  assign bus_sat.RegWriteAddr_ID = bus.RegWriteAddr_ID;
  assign bus_sat.Tnew_ID         = bus.Tnew_ID;
  assign bus_sat.flush           = bus.flush;

  hazard_scoreboard #(.TW(TW), .CNT_W(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  hazard_scoreboard #(.TW(TW), .CNT_W(2)) u_dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_sat)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a history of what entered EX each cycle (newest last).
  // An instruction's remaining Tnew is its Tnew on entry minus its age,
  // never below zero. The consumer waits on the nearest producer of the
  // register only while that producer is in EX or Mem.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0] dest;
    int         tnew;
  } ent_t;

  ent_t hist[$];
  int   model_cnt;

  function automatic int remaining(input int age);
    int t;
    t = hist[hist.size() - 1 - age].tnew - age;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic bit src_waits(input logic [4:0] ra, input int tuse);
    if (ra == 5'd0) return 1'b0;
    for (int age = 0; age < 2; age++) begin
      if (hist[hist.size() - 1 - age].dest == ra) return (remaining(age) > tuse);
    end
    return 1'b0;
  endfunction

  function automatic bit model_stall();
    return src_waits(bus.RAddr0_ID, int'(bus.Tuse_RAddr0_ID)) ||
           src_waits(bus.RAddr1_ID, int'(bus.Tuse_RAddr1_ID));
  endfunction

  task automatic model_reset();
    ent_t e;
    e.dest = 5'd0;
    e.tnew = 0;
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(e);
    model_cnt = 0;
  endtask

  task automatic model_step();
    ent_t e;
    bit   st;
    st = model_stall();
    if (st) model_cnt++;
    if (st || bus.flush) begin
      e.dest = 5'd0;
      e.tnew = 0;
    end else begin
      e.dest = bus.RegWriteAddr_ID;
      e.tnew = int'(bus.Tnew_ID);
    end
    hist.push_back(e);
    void'(hist.pop_front());
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_stall"},    int'(bus.stall),            int'(model_stall()));
    chk({tag, "_waddr_ex"}, int'(bus.RegWriteAddr_EX),  int'(hist[2].dest));
    chk({tag, "_tnew_ex"},  int'(bus.Tnew_WAddr_EX),    remaining(0));
    chk({tag, "_waddr_mem"},int'(bus.RegWriteAddr_Mem), int'(hist[1].dest));
    chk({tag, "_tnew_mem"}, int'(bus.Tnew_WAddr_Mem),   remaining(1));
    chk({tag, "_waddr_wb"}, int'(bus.RegWriteAddr_WB),  int'(hist[0].dest));
    chk({tag, "_count"},    int'(bus.stall_count),      model_cnt);
    chk({tag, "_count_sat"},int'(bus_sat.stall_count),  (model_cnt > 3) ? 3 : model_cnt);
  endtask

  task automatic set_in(input logic [4:0] ra0, input logic [4:0] ra1,
                        input logic [2:0] tu0, input logic [2:0] tu1,
                        input logic [4:0] wa,  input logic [2:0] tn,
                        input logic fl);
    bus.RAddr0_ID       = ra0;
    bus.RAddr1_ID       = ra1;
    bus.Tuse_RAddr0_ID  = tu0;
    bus.Tuse_RAddr1_ID  = tu1;
    bus.RegWriteAddr_ID = wa;
    bus.Tnew_ID         = tn;
    bus.flush           = fl;
  endtask

  // Advance one clock; inputs change again 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: inputs for the cycle and the outputs expected during it
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0] ra0, ra1;
    logic [2:0] tu0, tu1;
    logic [4:0] wa;
    logic [2:0] tn;
    logic       fl;
    logic       st;
    logic [4:0] ex;
    logic [2:0] tex;
    logic [4:0] mem;
    logic [2:0] tmem;
    logic [4:0] wb;
    int         cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [4:0] ra0, input logic [4:0] ra1,
                     input logic [2:0] tu0, input logic [2:0] tu1,
                     input logic [4:0] wa,  input logic [2:0] tn, input logic fl,
                     input logic st, input logic [4:0] ex, input logic [2:0] tex,
                     input logic [4:0] mem, input logic [2:0] tmem,
                     input logic [4:0] wb, input int cnt);
    vec_t v;
    v.ra0 = ra0; v.ra1 = ra1; v.tu0 = tu0; v.tu1 = tu1;
    v.wa = wa; v.tn = tn; v.fl = fl;
    v.st = st; v.ex = ex; v.tex = tex; v.mem = mem; v.tmem = tmem;
    v.wb = wb; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  initial begin
    //   ra0 ra1 tu0 tu1 wa tn fl | st ex tex mem tmem wb cnt
    // load-use: lw $8 then beq $8 (Tuse 0) -> two stall cycles
    add(0,  0, 0, 0,  8, 2, 0,   0,  0, 0,  0, 0,  0, 0);
    add(8,  0, 0, 0,  0, 0, 0,   1,  8, 2,  0, 0,  0, 0);
    add(8,  0, 0, 0,  0, 0, 0,   1,  0, 0,  8, 1,  0, 1);
    add(8,  0, 0, 0,  0, 0, 0,   0,  0, 0,  0, 0,  8, 2);
    // ALU result to a store (Tuse 2) -> no stall
    add(0,  0, 0, 0,  5, 1, 0,   0,  0, 0,  0, 0,  0, 2);
    add(0,  5, 0, 2,  0, 0, 0,   0,  5, 1,  0, 0,  0, 2);
    // producer of $0 with Tnew 2, then $0 consumer / jal $31
    add(0,  0, 0, 0,  0, 2, 0,   0,  0, 0,  5, 0,  0, 2);
    add(0,  0, 0, 0, 31, 0, 0,   0,  0, 2,  0, 0,  5, 2);
    add(31, 0, 0, 0,  9, 2, 0,   0, 31, 0,  0, 1,  0, 2);
    // nearest stage: EX $9 Tnew 0 hides Mem $9 Tnew 1
    add(0,  0, 0, 0,  9, 0, 0,   0,  9, 2, 31, 0,  0, 2);
    add(9,  0, 0, 0,  0, 0, 0,   0,  9, 0,  9, 1, 31, 2);
    // flush in the first stall cycle -> a single bubble
    add(0,  0, 0, 0,  3, 2, 0,   0,  0, 0,  9, 0,  9, 2);
    add(0,  3, 0, 0,  0, 0, 1,   1,  3, 2,  0, 0,  9, 2);
    add(0,  3, 0, 0,  0, 0, 0,   1,  0, 0,  3, 1,  0, 3);
    add(0,  3, 0, 0,  0, 0, 0,   0,  0, 0,  0, 0,  3, 4);
    // plain flush of a producer
    add(0,  0, 0, 0,  7, 1, 1,   0,  0, 0,  0, 0,  0, 4);
    // Tnew == Tuse is covered by forwarding
    add(0,  0, 0, 0,  6, 1, 0,   0,  0, 0,  0, 0,  0, 4);
    add(6,  0, 1, 0,  0, 0, 0,   0,  6, 1,  0, 0,  0, 4);
    // load then Tuse 1 consumer -> one stall cycle
    add(0,  0, 0, 0,  4, 2, 0,   0,  0, 0,  6, 0,  0, 4);
    add(0,  4, 0, 1,  0, 0, 0,   1,  4, 2,  0, 0,  6, 4);
    add(0,  4, 0, 1,  0, 0, 0,   0,  0, 0,  4, 1,  0, 5);
    add(0,  0, 0, 0,  0, 0, 0,   0,  0, 0,  0, 0,  4, 5);
  end

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    // reset state
    chk("reset_stall",     int'(bus.stall),            0);
    chk("reset_waddr_ex",  int'(bus.RegWriteAddr_EX),  0);
    chk("reset_tnew_ex",   int'(bus.Tnew_WAddr_EX),    0);
    chk("reset_waddr_mem", int'(bus.RegWriteAddr_Mem), 0);
    chk("reset_tnew_mem",  int'(bus.Tnew_WAddr_Mem),   0);
    chk("reset_waddr_wb",  int'(bus.RegWriteAddr_WB),  0);
    chk("reset_count",     int'(bus.stall_count),      0);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_reset();

    // directed table
    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].ra0, tbl[i].ra1, tbl[i].tu0, tbl[i].tu1,
             tbl[i].wa, tbl[i].tn, tbl[i].fl);
      #4;
      chk($sformatf("vec%0d_stall", i),     int'(bus.stall),            int'(tbl[i].st));
      chk($sformatf("vec%0d_waddr_ex", i),  int'(bus.RegWriteAddr_EX),  int'(tbl[i].ex));
      chk($sformatf("vec%0d_tnew_ex", i),   int'(bus.Tnew_WAddr_EX),    int'(tbl[i].tex));
      chk($sformatf("vec%0d_waddr_mem", i), int'(bus.RegWriteAddr_Mem), int'(tbl[i].mem));
      chk($sformatf("vec%0d_tnew_mem", i),  int'(bus.Tnew_WAddr_Mem),   int'(tbl[i].tmem));
      chk($sformatf("vec%0d_waddr_wb", i),  int'(bus.RegWriteAddr_WB),  int'(tbl[i].wb));
      chk($sformatf("vec%0d_count", i),     int'(bus.stall_count),      tbl[i].cnt);
      tick();
    end

    // two-bit counter has seen five stall cycles and must sit at 3
    chk("sat_count_hold", int'(bus_sat.stall_count), 3);

    // asynchronous reset between clock edges while stalled
    set_in(0, 0, 0, 0, 3, 2, 0);
    #4;
    tick();
    set_in(3, 0, 0, 0, 0, 0, 0);
    #2;
    chk("async_pre_stall", int'(bus.stall), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_stall",     int'(bus.stall),            0);
    chk("async_waddr_ex",  int'(bus.RegWriteAddr_EX),  0);
    chk("async_tnew_ex",   int'(bus.Tnew_WAddr_EX),    0);
    chk("async_waddr_mem", int'(bus.RegWriteAddr_Mem), 0);
    chk("async_tnew_mem",  int'(bus.Tnew_WAddr_Mem),   0);
    chk("async_waddr_wb",  int'(bus.RegWriteAddr_WB),  0);
    chk("async_count",     int'(bus.stall_count),      0);
    chk("async_count_sat", int'(bus_sat.stall_count),  0);
    #1;
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    model_reset();

    // randomized traffic on a few registers so hazards are frequent
    for (int n = 0; n < 400; n++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                         : 3'($urandom_range(0, 2)),
             ($urandom_range(0, 9) == 0));
      #4;
      check_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
